hazard_ctrl: RTL

- Issue controller for the decode stage.
- Keeps a per-register scoreboard of in-flight writes and withholds decode's issue handshake on read-after-write hazards, scoreboard saturation, flushes and drain requests.
- Sits beside decode: sees decode's register read addresses and destination, the downstream ready, write-back retirement and the execute-stage flush.

---
 rtl/ecap5_dproc_pkg.sv | 25 ++
 rtl/reg_scoreboard.sv | 72 +++++++
 rtl/hazard_ctrl.sv | 106 ++++++++++
 3 files changed

// File: rtl/ecap5_dproc_pkg.sv
// Shared types and constants for the decode-stage issue/hazard logic.
package ecap5_dproc_pkg;

  localparam int HAZARD_CNT_W = 2;
  localparam int REG_ADDR_W   = 5;
  localparam int NUM_REGS     = 32;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    FLUSH = 2'd1,
    DRAIN = 2'd2
  } hazard_state_t;

  // Record of the instruction most recently issued, still sitting in decode's output register.
  typedef struct packed {
    logic                  vld;
    logic                  wr;
    logic [REG_ADDR_W-1:0] addr;
  } youngest_t;

  function automatic logic reg_nz(input logic [REG_ADDR_W-1:0] a);
    return a != '0;
  endfunction

endpackage

// File: rtl/reg_scoreboard.sv
// Per-register saturating pending-write counters for x1..x31; x0 always reads zero.
module reg_scoreboard
  import ecap5_dproc_pkg::*;
#(
  parameter int CNT_W = HAZARD_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       inc_en,
  input  logic [4:0] inc_addr,
  input  logic       dec0_en,
  input  logic [4:0] dec0_addr,
  input  logic       dec1_en,
  input  logic [4:0] dec1_addr,
  input  logic [4:0] raddr0,
  input  logic [4:0] raddr1,
  input  logic [4:0] raddr2,
  output logic       nz0,
  output logic       nz1,
  output logic       nz2,
  output logic       max0,
  output logic       max1,
  output logic       max2,
  output logic       any_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W:0]   CNT_MAXW = {1'b0, CNT_MAX};

  // Entry 0 is reset to zero and never written, so x0 reads as idle.
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0] up, ndec, net;
  logic           inc_hit, d0_hit, d1_hit;

  always_comb begin
    cnt_d   = cnt_q;
    up      = '0;
    ndec    = '0;
    net     = '0;
    inc_hit = 1'b0;
    d0_hit  = 1'b0;
    d1_hit  = 1'b0;
    for (int i = 1; i < NUM_REGS; i++) begin
      inc_hit = inc_en  & (inc_addr  == 5'(i));
      d0_hit  = dec0_en & (dec0_addr == 5'(i));
      d1_hit  = dec1_en & (dec1_addr == 5'(i));
      up      = {1'b0, cnt_q[i]} + {{CNT_W{1'b0}}, inc_hit};
      ndec    = {{CNT_W{1'b0}}, d0_hit} + {{CNT_W{1'b0}}, d1_hit};
      // Extra decrements (flush + retire on an already-low count) floor at zero.
      if (up <= ndec) begin
        cnt_d[i] = '0;
      end else begin
        net = up - ndec;
        cnt_d[i] = (net > CNT_MAXW) ? CNT_MAX : net[CNT_W-1:0];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

  assign nz0      = |cnt_q[raddr0];
  assign nz1      = |cnt_q[raddr1];
  assign nz2      = |cnt_q[raddr2];
  assign max0     = reg_nz(raddr0) & (cnt_q[raddr0] == CNT_MAX);
  assign max1     = reg_nz(raddr1) & (cnt_q[raddr1] == CNT_MAX);
  assign max2     = reg_nz(raddr2) & (cnt_q[raddr2] == CNT_MAX);
  assign any_busy = |cnt_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-stage issue controller: RAW/saturation stalls, flush kill and drain handshake.
module hazard_ctrl
  import ecap5_dproc_pkg::*;
#(
  parameter int CNT_W = HAZARD_CNT_W
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       issue_valid_i,
  output logic       issue_ready_o,
  input  logic       ds_ready_i,
  input  logic [4:0] rs1_addr_i,
  input  logic [4:0] rs2_addr_i,
  input  logic       rs1_used_i,
  input  logic       rs2_used_i,
  input  logic [4:0] rd_addr_i,
  input  logic       rd_write_i,
  input  logic       retire_valid_i,
  input  logic [4:0] retire_addr_i,
  input  logic       flush_i,
  input  logic       drain_req_i,
  output logic       drain_done_o,
  output logic       busy_o
);

  hazard_state_t state_q, state_d;
  youngest_t     yng_q, yng_d;

  logic fire, hazard, sb_busy;
  logic rs1_nz, rs2_nz, rd_nz, rs1_max, rs2_max, rd_max;
  logic kill_en;

  reg_scoreboard #(.CNT_W(CNT_W)) u_sb (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .inc_en   (fire & rd_write_i & reg_nz(rd_addr_i)),
    .inc_addr (rd_addr_i),
    .dec0_en  (retire_valid_i & reg_nz(retire_addr_i)),
    .dec0_addr(retire_addr_i),
    .dec1_en  (kill_en),
    .dec1_addr(yng_q.addr),
    .raddr0   (rs1_addr_i),
    .raddr1   (rs2_addr_i),
    .raddr2   (rd_addr_i),
    .nz0      (rs1_nz),
    .nz1      (rs2_nz),
    .nz2      (rd_nz),
    .max0     (rs1_max),
    .max1     (rs2_max),
    .max2     (rd_max),
    .any_busy (sb_busy)
  );

  // Only the rd saturation flag and the source non-zero flags feed the stall.
  logic unused_flags;
  assign unused_flags = ^{rd_nz, rs1_max, rs2_max};

  // A flush kills whatever decode last handed downstream; undo its pending write.
  assign kill_en = flush_i & yng_q.vld & yng_q.wr & reg_nz(yng_q.addr);
  assign busy_o  = sb_busy | yng_q.vld;
  assign fire    = issue_valid_i & issue_ready_o;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= RUN;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      RUN:     if (flush_i) state_d = FLUSH;
               else if (drain_req_i) state_d = DRAIN;
      FLUSH:   state_d = flush_i ? FLUSH : RUN;
      DRAIN:   if (!drain_req_i) state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  // Hazard and ready depend only on operand fields and registered state, never on issue_valid_i.
  always_comb begin
    hazard = (rs1_used_i & reg_nz(rs1_addr_i) & rs1_nz)
           | (rs2_used_i & reg_nz(rs2_addr_i) & rs2_nz)
           | (rd_write_i & reg_nz(rd_addr_i)  & rd_max);
    issue_ready_o = ds_ready_i & ~hazard & (state_q == RUN) & ~flush_i & ~drain_req_i;
    drain_done_o  = (state_q == DRAIN) & ~busy_o;
  end

  always_comb begin
    yng_d = yng_q;
    if (flush_i) begin
      yng_d = '0;
    end else if (fire) begin
      yng_d.vld  = 1'b1;
      yng_d.wr   = rd_write_i;
      yng_d.addr = rd_addr_i;
    end else if (ds_ready_i) begin
      yng_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) yng_q <= '0;
    else         yng_q <= yng_d;
  end

endmodule
